// File: rtl/tm1640_rx_if.sv
// -----------------------------------------------------------------------------
// tm1640_rx_if
//
// Groups the TM1640 receiver's bus pins, display-RAM read port and decoded
// status outputs into one bundle.
//
//   tm_clk, tm_din : two-wire TM1640 bus (asynchronous to the system clock)
//   rd_addr        : display RAM read address
//   rd_data        : registered display RAM read data
//   disp_on        : display-control on bit
//   brightness     : display-control pulse width
//   busy           : frame in progress (start seen, stop not yet seen)
//   byte_valid     : one-cycle pulse per completed byte
//   byte_data      : last completed byte, held
//   byte_is_cmd    : completed byte was the first byte of its frame
//   frame_err      : one-cycle pulse on a protocol error
//
// Modports: master drives the bus and read address (bench / host side);
// slave is the receiver itself.
// -----------------------------------------------------------------------------
interface tm1640_rx_if;
    logic       tm_clk;
    logic       tm_din;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       disp_on;
    logic [2:0] brightness;
    logic       busy;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_is_cmd;
    logic       frame_err;

    modport master (
        output tm_clk, tm_din, rd_addr,
        input  rd_data, disp_on, brightness, busy,
        input  byte_valid, byte_data, byte_is_cmd, frame_err
    );

    modport slave (
        input  tm_clk, tm_din, rd_addr,
        output rd_data, disp_on, brightness, busy,
        output byte_valid, byte_data, byte_is_cmd, frame_err
    );
endinterface

// File: rtl/tm1640_rx.sv
// -----------------------------------------------------------------------------
// tm1640_rx
//
// Emulates the receiving side of a TM1640 LED driver. The bus pins are
// oversampled in the clk domain, start/stop/bit events are decoded, bytes are
// assembled LSB-first, and data / display-control / address commands update a
// 16x8 display RAM plus the display on/brightness state.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : tm1640_rx_if.slave (bus pins, RAM read port, decoded outputs)
//
// Parameter:
//   STABLE_CNT : consecutive differing samples needed before a filtered input
//                changes (only meaningful with the glitch filter).
//
// Optional feature macro: TM1640_RX_GLITCH_FILTER_EN
//   defined   -> each synchronized input passes a saturating stability filter
//   undefined -> synchronized inputs feed edge detection directly
// -----------------------------------------------------------------------------
module tm1640_rx #(
    parameter int STABLE_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    tm1640_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_IGNORE
    } state_t;

    genvar gi;

    // ------------------------------------------------------------------
    // Input synchronizers. Reset to 1 so an idle (high) bus produces no
    // spurious edges when reset is released.
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_din_sync;
    logic [1:0] w_sync;     // [0] = clk, [1] = din
    logic [1:0] w_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_din_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.tm_clk};
            r_din_sync <= {r_din_sync[0], bus.tm_din};
        end
    end

    assign w_sync = {r_din_sync[1], r_clk_sync[1]};

`ifdef TM1640_RX_GLITCH_FILTER_EN
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic             r_filt;
            logic [CNT_W-1:0] r_cnt;

            // The counter tracks how long the input has disagreed with the
            // filtered value; any agreeing sample restarts the count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_filt <= 1'b1;
                    r_cnt  <= '0;
                end else if (w_sync[gi] == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == CNT_W'(STABLE_CNT - 1)) begin
                    r_filt <= w_sync[gi];
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate
`else
    assign w_filt = w_sync;
`endif

    // ------------------------------------------------------------------
    // Edge / event decode
    // ------------------------------------------------------------------
    logic r_clk_prev;
    logic r_din_prev;
    logic w_clk_cur;
    logic w_din_cur;
    logic w_start;
    logic w_stop;
    logic w_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_prev <= 1'b1;
            r_din_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_cur;
            r_din_prev <= w_din_cur;
        end
    end

    assign w_clk_cur = w_filt[0];
    assign w_din_cur = w_filt[1];

    // Start/stop require tm_clk high in both samples, so a simultaneous
    // clk+din change can only ever be a bit edge.
    assign w_start = w_clk_cur & r_clk_prev &  r_din_prev & ~w_din_cur;
    assign w_stop  = w_clk_cur & r_clk_prev & ~r_din_prev &  w_din_cur;
    assign w_bit   = w_clk_cur & ~r_clk_prev;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] w_byte;
    logic       w_bit_taken;
    logic       w_byte_done;

    assign w_bit_taken = w_bit && (r_state != ST_IDLE);
    assign w_byte_done = w_bit_taken && (r_bit_cnt == 3'd7);
    // LSB-first: new bits enter at the top and move down, so after eight
    // bits the first one received sits in bit 0.
    assign w_byte      = {w_din_cur, r_shift[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_start || w_stop) begin
                r_bit_cnt <= '0;
            end else if (w_bit_taken) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_bit_taken) begin
                r_shift <= w_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic w_frame_err;
    logic w_we;
    logic w_is_cmd;
    logic w_cmd_data;
    logic w_cmd_disp;
    logic w_cmd_addr;

    always_comb begin
        w_state_next = r_state;
        w_frame_err  = 1'b0;
        w_we         = 1'b0;
        w_is_cmd     = 1'b0;
        w_cmd_data   = 1'b0;
        w_cmd_disp   = 1'b0;
        w_cmd_addr   = 1'b0;

        if (w_start) begin
            // Repeated start mid-byte drops the partial byte.
            if ((r_state != ST_IDLE) && (r_bit_cnt != 3'd0)) begin
                w_frame_err = 1'b1;
            end
            w_state_next = ST_CMD;
        end else if (w_stop && (r_state != ST_IDLE)) begin
            if (r_bit_cnt != 3'd0) begin
                w_frame_err = 1'b1;
            end
            w_state_next = ST_IDLE;
        end else if (w_byte_done) begin
            case (r_state)
                ST_CMD: begin
                    w_is_cmd = 1'b1;
                    case (w_byte[7:6])
                        2'b01: begin
                            w_cmd_data   = 1'b1;
                            w_state_next = ST_IGNORE;
                        end
                        2'b10: begin
                            w_cmd_disp   = 1'b1;
                            w_state_next = ST_IGNORE;
                        end
                        2'b11: begin
                            w_cmd_addr   = 1'b1;
                            w_state_next = ST_DATA;
                        end
                        default: begin
                            w_frame_err  = 1'b1;
                            w_state_next = ST_IGNORE;
                        end
                    endcase
                end
                ST_DATA:   w_we        = 1'b1;
                ST_IGNORE: w_frame_err = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Command state, byte outputs, error pulse
    // ------------------------------------------------------------------
    logic       r_addr_mode;   // 0 = auto-increment, 1 = fixed
    logic [3:0] r_wr_addr;
    logic       r_disp_on;
    logic [2:0] r_brightness;
    logic       r_byte_valid;
    logic [7:0] r_byte_data;
    logic       r_byte_is_cmd;
    logic       r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_mode   <= 1'b0;
            r_wr_addr     <= '0;
            r_disp_on     <= 1'b0;
            r_brightness  <= '0;
            r_byte_valid  <= 1'b0;
            r_byte_data   <= '0;
            r_byte_is_cmd <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_done;
            r_frame_err  <= w_frame_err;
            if (w_byte_done) begin
                r_byte_data   <= w_byte;
                r_byte_is_cmd <= w_is_cmd;
            end
            if (w_cmd_data) begin
                r_addr_mode <= w_byte[2];
            end
            if (w_cmd_disp) begin
                r_disp_on    <= w_byte[3];
                r_brightness <= w_byte[2:0];
            end
            if (w_cmd_addr) begin
                r_wr_addr <= w_byte[3:0];
            end else if (w_we && !r_addr_mode) begin
                r_wr_addr <= r_wr_addr + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display RAM: one register per entry so the whole array clears on reset.
    // ------------------------------------------------------------------
    logic [7:0] w_ram [16];
    logic [7:0] r_rd_data;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_ram
            logic [7:0] r_mem;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem <= '0;
                end else if (w_we && (r_wr_addr == 4'(gi))) begin
                    r_mem <= w_byte;
                end
            end

            assign w_ram[gi] = r_mem;
        end
    endgenerate

    // Registered read sees the pre-write value on a same-cycle collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_ram[bus.rd_addr];
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.disp_on     = r_disp_on;
    assign bus.brightness  = r_brightness;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.byte_valid  = r_byte_valid;
    assign bus.byte_data   = r_byte_data;
    assign bus.byte_is_cmd = r_byte_is_cmd;
    assign bus.frame_err   = r_frame_err;

endmodule
